spi_a2d_resp: RTL

SPI_A2D_RESP -- requirements
Module: spi_a2d_resp

---
 rtl/spi_a2d_pkg.sv | 18 +
 rtl/spi_edge_det.sv | 42 ++++
 rtl/spi_a2d_resp.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/spi_a2d_pkg.sv
// rtl/spi_a2d_pkg.sv - shared constants and FSM state type for the SPI A/D responder
package spi_a2d_pkg;

  localparam int DATA_W    = 12;
  localparam int FRM_BITS  = 16;
  localparam int NUM_CHNL  = 8;
  localparam int CHNL_W    = $clog2(NUM_CHNL);
  localparam int CNT_W     = 5;
  // Channel field position inside the received command word
  localparam int CHNL_LSB  = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2
  } state_e;

endpackage

// File: rtl/spi_edge_det.sv
// rtl/spi_edge_det.sv - input synchronizer with registered rise/fall pulses
module spi_edge_det #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  // Synchronizer chain, then compare last stage against its delayed copy;
  // pulses and lvl_o are aligned and appear SYNC_STAGES+1 clk after the input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign lvl_o  = prev_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_a2d_resp.sv
// rtl/spi_a2d_resp.sv - SPI mode-0 slave returning stored A/D channel values; SPI_A2D_AUTOINC_EN adds post-read increment
module spi_a2d_resp
  import spi_a2d_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic              wr_en,
  input  logic [CHNL_W-1:0] wr_chnl,
  input  logic [DATA_W-1:0] wr_data,
  output logic              cmd_vld,
  output logic [CHNL_W-1:0] cmd_chnl,
  output logic              frm_err
);

  logic ss_lvl, ss_rise, ss_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_det (
    .clk(clk), .rst_n(rst_n), .d_i(SS_n),
    .lvl_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  spi_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_det (
    .clk(clk), .rst_n(rst_n), .d_i(SCLK),
    .lvl_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_det (
    .clk(clk), .rst_n(rst_n), .d_i(MOSI),
    .lvl_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   regs_q [NUM_CHNL];
  logic [FRM_BITS-1:0] tx_q;
  logic [FRM_BITS-1:0] rx_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CHNL_W-1:0]   cmd_chnl_q;
  logic                cmd_vld_q;
  logic                frm_err_q;

  logic load_tx, rx_shift, tx_shift, frm_ok, frm_bad;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-cycle datapath controls; SCLK edges outside a frame fall through IDLE untouched
  always_comb begin
    state_d  = state_q;
    load_tx  = 1'b0;
    rx_shift = 1'b0;
    tx_shift = 1'b0;
    frm_ok   = 1'b0;
    frm_bad  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = ARMED;
          load_tx = 1'b1;
        end
      end
      ARMED: begin
        if (ss_rise) begin
          state_d = IDLE;
          frm_bad = 1'b1;
        end else if (sclk_rise) begin
          state_d  = SHIFT;
          rx_shift = 1'b1;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d = IDLE;
          if (cnt_q == CNT_W'(FRM_BITS)) frm_ok  = 1'b1;
          else                           frm_bad = 1'b1;
        end else begin
          rx_shift = sclk_rise;
          tx_shift = sclk_fall;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift registers, bit counter and frame-end results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q       <= '0;
      rx_q       <= '0;
      cnt_q      <= '0;
      cmd_chnl_q <= '0;
      cmd_vld_q  <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      // The read uses the channel from the previous frame; regs_q still holds the pre-write value this cycle
      if (load_tx) begin
        tx_q <= {{(FRM_BITS-DATA_W){1'b0}}, regs_q[cmd_chnl_q]};
      end else if (tx_shift) begin
        tx_q <= {tx_q[FRM_BITS-2:0], 1'b0};
      end
      if (load_tx) begin
        rx_q  <= '0;
        cnt_q <= '0;
      end else if (rx_shift) begin
        rx_q <= {rx_q[FRM_BITS-2:0], mosi_lvl};
        if (cnt_q != CNT_W'(FRM_BITS)) cnt_q <= cnt_q + 1'b1;
      end
      if (frm_ok) cmd_chnl_q <= rx_q[CHNL_LSB +: CHNL_W];
      cmd_vld_q <= frm_ok;
      frm_err_q <= frm_bad;
    end
  end

`ifdef SPI_A2D_AUTOINC_EN
  logic inc_pend_q;

  // Channel register file; the increment lands one clk after the load, a host write to the same entry wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHNL; i++) regs_q[i] <= '0;
      inc_pend_q <= 1'b0;
    end else begin
      inc_pend_q <= load_tx;
      if (inc_pend_q && !(wr_en && (wr_chnl == cmd_chnl_q))) begin
        regs_q[cmd_chnl_q] <= regs_q[cmd_chnl_q] + 1'b1;
      end
      if (wr_en) regs_q[wr_chnl] <= wr_data;
    end
  end
`else
  // Channel register file, written only by the host port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHNL; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wr_chnl] <= wr_data;
    end
  end
`endif

  logic unused_sig;
  assign unused_sig = ^{sclk_lvl, mosi_rise, mosi_fall,
                        rx_q[FRM_BITS-1:CHNL_LSB+CHNL_W], rx_q[CHNL_LSB-1:0]};

  assign MISO     = ss_lvl ? 1'b0 : tx_q[FRM_BITS-1];
  assign cmd_vld  = cmd_vld_q;
  assign cmd_chnl = cmd_chnl_q;
  assign frm_err  = frm_err_q;

endmodule
